data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port round-robin arbiter that shares the single-ported `Data_Memory` between the CPU load/store path (requester 0) and the auxiliary string/debug port (requester 1). Each requester issues one word transaction at a time through a req/ack handshake. The arbiter registers the winning request, drives the memory port for exactly one full clock cycle, and returns read data with an ack. It also rejects accesses that are misaligned or that fall outside the memory window; those are answered with an error and never touch the memory.

## Interface
- `STACK_TOP`, 32'h7ffffffc: byte address of the highest legal word.
- `WINDOW_WORDS`, 256: legal word indices span `(STACK_TOP>>2)-WINDOW_WORDS` through `STACK_TOP>>2` inclusive.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `r0_req`, `r1_req`  in  1  request; held high until the matching ack is seen.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read; stable while req is high.
- `r0_addr`, `r1_addr`  in  32  byte address.
- `r0_wdata`, `r1_wdata`  in  32  write data.
- `r0_ack`, `r1_ack`  out  1  one-cycle completion pulse.
- `r0_err`, `r1_err`  out  1  pulses with ack when the access was rejected.
- `r0_rdata`, `r1_rdata`  out  32  read data, valid while ack is high; holds its value otherwise.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `mem_address`, `mem_write_data`  out  32  memory address and write data.
- `mem_read_data`  in  32  combinational read data from memory.

## Operation
- States: IDLE, ACCESS, RESP. Encoded state, `last_grant`, the latched request, and all outputs are cleared by `rst_n` low.
- Reset values: all acks and errs 0, both rdata 0, `mem_read`/`mem_write` 0, `mem_address`/`mem_write_data` 0, state IDLE, `last_grant` = 1.
- **IDLE:**
  - If any req is high, pick the winner.
  - With only one requester active, that requester wins.
  - With both active, the requester not equal to `last_grant` wins, so requester 0 wins the first tie after reset.
  - Latch the winner's we, addr, wdata and id, update `last_grant`, and move to ACCESS.
- **Legality check** is evaluated on the latched address. An access is legal only if:
  - `addr[1:0] == 0`, and
  - `addr>>2` lies within the window, with both bounds inclusive.
- **ACCESS (exactly one cycle):**
  - `mem_address` and `mem_write_data` come from the latched values.
  - If legal, `mem_write` = we and `mem_read` = !we. If illegal, both strobes are 0.
  - The write commits at the memory's mid-cycle falling edge.
  - On the closing rising edge: set the winner's ack = 1 and err = !legal. For a legal read, load `mem_read_data` into the winner's rdata. For an error, load 0. For a legal write, leave rdata unchanged. Move to RESP.
- **RESP (one cycle):** ack and err are high. No new grant is made. Go to IDLE, clearing ack and err on that edge.
- Memory strobes are decoded combinationally from state and the legal bit. `mem_write` is 0 in every state other than ACCESS.
- A requester must drop, or re-issue, req at the edge where it samples ack. Req still high in the cycle after RESP is treated as a new request.

## Timing
- Req first high in cycle N while the arbiter is in IDLE:
  - ACCESS occurs in cycle N+1.
  - Ack is high in cycle N+2.
  - The earliest next grant is at the end of cycle N+3.
- Peak throughput is one transaction per 3 cycles.
- Worst-case wait under continuous contention is 6 cycles from req to ack.
- Simultaneous requests in IDLE resolve in a single cycle; the loser is granted on the next IDLE.
- A req arriving during ACCESS or RESP is held off until IDLE. No request is lost, because req is level-held.
- Reset asserted mid-ACCESS:
  - `mem_write` and `mem_read` drop immediately (asynchronous), so no write commits at the following falling edge.
  - No ack is issued.
  - After release, the arbiter is in IDLE with `last_grant` = 1.
- Boundary addresses:
  - Lowest legal: `STACK_TOP - 4*WINDOW_WORDS`.
  - Highest legal: `STACK_TOP`.
  - One word below the lowest, one word above the highest, and any address with `addr[1:0]` ≠ 0 are errors.

## Test plan
- Requester 0 writes 32'hDEADBEEF to 32'h7ffffffc, then reads it back: ack in the second cycle after req, err = 0, rdata = 32'hDEADBEEF. Exactly one cycle has `mem_write` high.
- Both reqs are raised in the same cycle after reset, with writes to 32'h7ffffff8 and 32'h7ffffff4: r0 is acked first and r1 three cycles later. With both reqs held continuously, grants alternate r0, r1, r0.
- Requester 1 reads 32'h7ffffffe (misaligned), then `32'h7ffffffc + 4`, then `STACK_TOP - 4*257`: each returns ack with err = 1 and rdata = 0, `mem_read` and `mem_write` are never asserted, and memory contents are unchanged.
- The lowest legal word `32'h7ffffbfc` is written with 32'h12345678 and read back: err = 0, rdata = 32'h12345678.
- `rst_n` is pulsed low during the ACCESS cycle of a write of 32'hCAFEF00D: no ack, the target word keeps its old value, and all outputs are at reset values. A new request after release completes normally.
- Requester 0 keeps req high through ack: it is re-served as a new transaction, and requester 1 is still granted within 6 cycles.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares the single-ported data memory between the
// CPU load/store path (requester 0) and the string/debug port (requester 1).
//
// state  | meaning
// IDLE   | waiting for a request; grants the winner and latches its access
// ACCESS | drives the memory port for one full cycle (strobes only if legal)
// RESP   | ack/err high for the winner; no new grant this cycle
module data_mem_arbiter #(
    parameter logic [31:0] STACK_TOP    = 32'h7ffffffc,
    parameter int          WINDOW_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_err,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [31:0] r1_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [29:0] WORD_HI = STACK_TOP[31:2];
    localparam logic [29:0] WORD_LO = WORD_HI - 30'(WINDOW_WORDS);

    state_t      state, state_nxt;
    logic        last_grant;
    logic        lat_id;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        legal;
    logic        grant_valid;
    logic        grant_id;

    assign legal = (lat_addr[1:0] == 2'b00) &&
                   (lat_addr[31:2] >= WORD_LO) && (lat_addr[31:2] <= WORD_HI);

    // On a tie the requester that did not win last time takes the grant.
    assign grant_valid = r0_req | r1_req;
    assign grant_id    = (r0_req & r1_req) ? ~last_grant : r1_req;

    assign mem_address    = lat_addr;
    assign mem_write_data = lat_wdata;

    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_write = legal & lat_we;
                mem_read  = legal & ~lat_we;
                state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            r0_ack     <= 1'b0;
            r0_err     <= 1'b0;
            r0_rdata   <= '0;
            r1_ack     <= 1'b0;
            r1_err     <= 1'b0;
            r1_rdata   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_id     <= grant_id;
                        last_grant <= grant_id;
                        lat_we     <= grant_id ? r1_we    : r0_we;
                        lat_addr   <= grant_id ? r1_addr  : r0_addr;
                        lat_wdata  <= grant_id ? r1_wdata : r0_wdata;
                    end
                end
                ACCESS: begin
                    // Writes leave rdata alone; rejected accesses return zero.
                    if (!lat_id) begin
                        r0_ack <= 1'b1;
                        r0_err <= ~legal;
                        if (!legal)       r0_rdata <= '0;
                        else if (!lat_we) r0_rdata <= mem_read_data;
                    end else begin
                        r1_ack <= 1'b1;
                        r1_err <= ~legal;
                        if (!legal)       r1_rdata <= '0;
                        else if (!lat_we) r1_rdata <= mem_read_data;
                    end
                end
                RESP: begin
                    r0_ack <= 1'b0;
                    r0_err <= 1'b0;
                    r1_ack <= 1'b0;
                    r1_err <= 1'b0;
                end
                default: begin
                    r0_ack <= 1'b0;
                    r1_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random single transactions
// checked against a word-array reference of the memory window.
module tb_data_mem_arbiter;

    localparam logic [31:0] STACK_TOP = 32'h7ffffffc;
    localparam int          WW        = 256;
    localparam logic [31:0] LOW       = STACK_TOP - 32'(4 * WW);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [31:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
    logic        r0_ack, r0_err, r1_ack, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] phys [0:WW];
    logic [31:0] refm [0:WW];
    logic [31:0] ref_rd [0:1];
    logic        init_en = 1'b1;
    int          wcnt = 0, rcnt = 0, bad_write = 0;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initval(int i);
        return (32'(i) * 32'h9e3779b9) ^ 32'h5a5a5a5a;
    endfunction

    function automatic bit in_window(logic [31:0] a);
        return ((a >> 2) >= (LOW >> 2)) && ((a >> 2) <= (STACK_TOP >> 2));
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) - (LOW >> 2));
    endfunction

    // Memory model: combinational read, write commits on the falling edge.
    always_comb begin
        mem_read_data = 32'hbad0bad0;
        if (in_window(mem_address)) mem_read_data = phys[widx(mem_address)];
    end

    always @(negedge clk) begin
        if (init_en) begin
            for (int i = 0; i <= WW; i++) phys[i] <= initval(i);
        end else begin
            if (mem_write) begin
                wcnt <= wcnt + 1;
                if (in_window(mem_address)) phys[widx(mem_address)] <= mem_write_data;
                else bad_write <= bad_write + 1;
            end
            if (mem_read) rcnt <= rcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(int id);
        return (id != 0) ? r1_ack : r0_ack;
    endfunction

    function automatic logic err_of(int id);
        return (id != 0) ? r1_err : r0_err;
    endfunction

    function automatic logic [31:0] rd_of(int id);
        return (id != 0) ? r1_rdata : r0_rdata;
    endfunction

    task automatic set_req(input int id, input bit rq, input bit we,
                           input logic [31:0] a, input logic [31:0] d);
        if (id == 0) begin
            r0_req = rq; r0_we = we; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = rq; r1_we = we; r1_addr = a; r1_wdata = d;
        end
    endtask

    // Reference: what a completed access must return and do to memory.
    task automatic model(input int id, input bit we, input logic [31:0] a,
                         input logic [31:0] d, output bit exp_err, output logic [31:0] exp_rd);
        bit ok;
        ok = (a[1:0] == 2'b00) && in_window(a);
        exp_err = !ok;
        if (!ok)      exp_rd = '0;
        else if (we) begin
            refm[widx(a)] = d;
            exp_rd = ref_rd[id];
        end else      exp_rd = refm[widx(a)];
        ref_rd[id] = exp_rd;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " r0_ack"}, r0_ack, 0);
        check({tag, " r1_ack"}, r1_ack, 0);
        check({tag, " r0_err"}, r0_err, 0);
        check({tag, " r1_err"}, r1_err, 0);
        check({tag, " r0_rdata"}, r0_rdata, 0);
        check({tag, " r1_rdata"}, r1_rdata, 0);
        check({tag, " mem_read"}, mem_read, 0);
        check({tag, " mem_write"}, mem_write, 0);
        check({tag, " mem_address"}, mem_address, 0);
        check({tag, " mem_write_data"}, mem_write_data, 0);
    endtask

    // Single uncontended transaction, started from IDLE at posedge+1.
    task automatic txn(input int id, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
        int lat, w0, rd0;
        bit exp_err, ok;
        logic [31:0] exp_rd;
        w0 = wcnt; rd0 = rcnt; lat = 0;
        ok = (a[1:0] == 2'b00) && in_window(a);
        set_req(id, 1, we, a, d);
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (ack_of(id)) lat = i;
        end
        set_req(id, 0, we, a, d);
        model(id, we, a, d, exp_err, exp_rd);
        check({tag, " latency"}, lat, 2);
        check({tag, " err"}, err_of(id), exp_err);
        check({tag, " rdata"}, rd_of(id), exp_rd);
        check({tag, " writes"}, wcnt - w0, (ok && we) ? 1 : 0);
        check({tag, " reads"}, rcnt - rd0, (ok && !we) ? 1 : 0);
        @(posedge clk); #1;
        check({tag, " ack drop"}, ack_of(id), 0);
    endtask

    // Both requesters held from the same cycle: grants r0, r1, r0.
    task automatic race(input bit we, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1, input string tag);
        bit e0, e1, exp_err;
        logic [31:0] exp_rd;
        set_req(0, 1, we, a0, d0);
        set_req(1, 1, we, a1, d1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            e0 = (i == 2) || (i == 8);
            e1 = (i == 5);
            check($sformatf("%s ack0 c%0d", tag, i), r0_ack, e0);
            check($sformatf("%s ack1 c%0d", tag, i), r1_ack, e1);
            if (e0) begin
                model(0, we, a0, d0, exp_err, exp_rd);
                check({tag, " rdata0"}, r0_rdata, exp_rd);
            end
            if (e1) begin
                model(1, we, a1, d1, exp_err, exp_rd);
                check({tag, " rdata1"}, r1_rdata, exp_rd);
            end
        end
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int k, lat1, n0, w0, sel, mism, id;
        bit we, exp_err, r1_done;
        logic [31:0] a, d, exp_rd;

        for (int i = 0; i <= WW; i++) refm[i] = initval(i);
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        @(negedge clk); #1;
        init_en = 1'b0;

        do_reset();
        check_reset_vals("reset");

        w0 = wcnt;
        txn(0, 1, STACK_TOP, 32'hdeadbeef, "r0 wr top");
        txn(0, 0, STACK_TOP, 32'h0, "r0 rd top");
        check("r0 rd top value", r0_rdata, 32'hdeadbeef);
        check("top one write", wcnt - w0, 1);

        do_reset();
        race(1'b1, 32'h7ffffff8, 32'h11111111, 32'h7ffffff4, 32'h22222222, "race wr");

        txn(1, 0, 32'h7ffffffe, 32'h0, "r1 misaligned");
        txn(1, 0, STACK_TOP + 32'd4, 32'h0, "r1 above");
        txn(1, 0, STACK_TOP - 32'(4 * 257), 32'h0, "r1 below");
        txn(0, 1, LOW - 32'd4, 32'h0badf00d, "r0 wr below");
        txn(1, 1, STACK_TOP + 32'd4, 32'h0badf00d, "r1 wr above");

        txn(1, 1, LOW, 32'h12345678, "wr low");
        txn(1, 0, LOW, 32'h0, "rd low");
        check("rd low value", r1_rdata, 32'h12345678);

        a = 32'h7ffffff0;
        txn(0, 1, a, 32'h55aa55aa, "pre wr");
        set_req(0, 1, 1, a, 32'hcafef00d);
        @(posedge clk); #1;
        check("mid access strobe", mem_write, 1);
        #1 rst_n = 1'b0;
        #1;
        set_req(0, 0, 0, '0, '0);
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        check_reset_vals("mid reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid reset no ack", r0_ack, 0);
        check("mid reset word kept", phys[widx(a)], 32'h55aa55aa);
        race(1'b0, a, 32'h0, STACK_TOP, 32'h0, "race rd");

        // Requester 0 keeps req high through ack; requester 1 joins later.
        k = $urandom_range(1, 4);
        lat1 = 0; n0 = 0; r1_done = 0;
        set_req(0, 1, 0, STACK_TOP, 32'h0);
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (i == k) set_req(1, 1, 0, LOW, 32'h0);
            if (r0_ack) begin
                n0++;
                model(0, 0, STACK_TOP, 32'h0, exp_err, exp_rd);
                check("hold r0 rdata", r0_rdata, exp_rd);
            end
            if (r1_ack && !r1_done) begin
                r1_done = 1;
                lat1 = i - k;
                model(1, 0, LOW, 32'h0, exp_err, exp_rd);
                check("hold r1 rdata", r1_rdata, exp_rd);
                set_req(1, 0, 0, '0, '0);
            end
        end
        set_req(0, 0, 0, '0, '0);
        repeat (4) @(posedge clk);
        #1;
        check("hold r1 served", r1_done, 1);
        check("hold r1 wait <= 6", (lat1 >= 2) && (lat1 <= 6), 1);
        check("hold r0 reserved", n0 >= 2, 1);

        for (int n = 0; n < 40; n++) begin
            id  = int'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            sel = int'($urandom_range(0, 5));
            case (sel)
                3:       a = LOW + 32'(4 * $urandom_range(0, WW)) + 32'($urandom_range(1, 3));
                4:       a = LOW - 32'(4 * $urandom_range(1, 8));
                5:       a = STACK_TOP + 32'(4 * $urandom_range(1, 8));
                default: a = LOW + 32'(4 * $urandom_range(0, WW));
            endcase
            txn(id, we, a, d, $sformatf("rand%0d", n));
        end

        mism = 0;
        for (int i = 0; i <= WW; i++) if (phys[i] !== refm[i]) mism++;
        check("memory image", mism, 0);
        check("no stray writes", bad_write, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
